mul_share_arb: RTL
==================

Name: mul_share_arb

Overview:
- Arbitrates NREQ requesters onto one shared, fully pipelined multiplier: 53b x 27b operands, 80b product, fixed latency LAT.
- Replaces the static "port 0 wins" multiplier mux in the FMA top level with round-robin or fixed-priority arbitration and per-requester in-flight limits.
- Tracks which requester issued each operation through a tag pipeline and returns the product with a one-hot per-requester valid.

Parameters:
NREQ, 2, number of requesters (2..8)
LAT, 3, multiplier latency in cycles from en to out valid (1..8)
MAXOUT, 2, max in-flight ops per requester (1..LAT)
RR, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset; 0 = reset asserted
req  in  NREQ  per-requester operation request
req_in_1  in  NREQ*53  operand A, requester i at [i*53+:53]
req_in_2  in  NREQ*27  operand B, requester i at [i*27+:27]
gnt  out  NREQ  one-hot grant, combinational, same cycle as accepted req
mul_en  out  1  enable to shared multiplier
mul_in_1  out  53  operand A to multiplier
mul_in_2  out  27  operand B to multiplier
mul_out  in  80  multiplier product, valid LAT cycles after mul_en
rvld  out  NREQ  one-hot result valid, one cycle per completed op
rslt  out  80  product broadcast to all requesters (registered)
inflight  out  NREQ*4  per-requester outstanding count, [i*4+:4]

Behaviour:
- Reset (reset=0, async):
  - tag pipeline valid bits, inflight counters, rvld and rslt cleared to 0.
  - RR pointer set to 0.
  - gnt and mul_en are forced to 0 while reset=0.
- Eligibility: eligible[i] = req[i] & (inflight[i] < MAXOUT). A completion (rvld[i]) in the same cycle does NOT free a slot for that cycle's arbitration.
- Arbitration:
  - Combinational; at most one gnt bit per cycle.
  - RR=1: search from pointer upward, wrapping mod NREQ. The first eligible index wins. On grant to k, pointer <= (k+1) mod NREQ. Pointer is unchanged when there is no grant.
  - RR=0: lowest eligible index wins; pointer unused.
- Datapath drive:
  - mul_en = |gnt.
  - mul_in_1/mul_in_2 = operands of the granted requester.
  - When there is no grant, operands are 0.
- Handshake:
  - The requester holds req and operands until it sees gnt.
  - req & gnt in a cycle = op accepted. No back-pressure on results.
- Tag pipeline:
  - LAT-stage shift register of {valid, index}.
  - Stage 0 is loaded with {mul_en, granted index} each cycle.
  - At stage LAT-1 with valid=1, in the next cycle: rvld[index] <= 1 and rslt <= mul_out. Net effect: rvld asserts LAT+1 cycles after gnt.
  - rslt holds its last value when rvld=0.
- Counters:
  - inflight[i] +1 on gnt[i], -1 on rvld[i]. Both in the same cycle = unchanged.
  - Never exceeds MAXOUT and never underflows; underflow is an assertion error in the bench.
- Throughput: one op per cycle total; back-to-back grants to the same requester are allowed up to MAXOUT.
- Reset mid-operation: all in-flight ops are discarded. No rvld is ever produced for ops granted before reset asserted.
- Unrequested index: rvld bit stays 0; rslt is not updated.

Test Plan:
- Single op, LAT=3: req[0]=1 with A=53'd3, B=27'd5 at cycle 0 -> gnt=2'b01 at cycle 0; mul_en=1; rvld=2'b01 with rslt=80'd15 at cycle 4; inflight[0] reads 1 during cycles 1-4 and 0 from cycle 5.
- RR fairness: req=2'b11 held continuously, MAXOUT=2 -> gnt alternates 01,10,01,10; no requester is granted twice in a row; the returned rvld sequence matches the grant order.
- Fixed priority RR=0: req=2'b11 held continuously -> gnt=01 for cycles 0-1; cycles 2-3 gnt=10 as requester 0 is capped at MAXOUT=2; from cycle 4 requester 0 is granted again whenever inflight[0]<2.
- In-flight cap: req[0] only, held high, MAXOUT=2 -> grants at cycles 0 and 1, no grant at cycles 2-4; the next grant occurs in the cycle after the first rvld (cycle 5).
- Simultaneous grant and completion: requester 0 has one op returning in the same cycle it is granted a new op -> inflight[0] is unchanged that cycle; rslt shows the old product.
- Reset mid-flight: grant 2 ops, assert reset=0 for 1 cycle at cycle 2 -> rvld stays 0 for 10 cycles; inflight=0; the next grant goes to requester 0 (pointer reset).

Source files
------------

// File: rtl/mul_share_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_arb_if
//  Description : Bundle of every requester-side and multiplier-side signal of
//                the shared-multiplier arbiter.
//                  slave  : arbiter view (takes requests, drives the multiplier
//                           operands, returns results)
//                  master : environment view (requesters plus the multiplier)
//  Signals     : req[NREQ]          per-requester operation request
//                req_in_1[NREQ*53]  operand A, requester i at [i*53+:53]
//                req_in_2[NREQ*27]  operand B, requester i at [i*27+:27]
//                gnt[NREQ]          one-hot grant (same cycle as accepted req)
//                mul_en             shared multiplier enable
//                mul_in_1[53]       operand A to multiplier
//                mul_in_2[27]       operand B to multiplier
//                mul_out[80]        multiplier product, LAT cycles after mul_en
//                rvld[NREQ]         one-hot result valid
//                rslt[80]           registered product broadcast
//                inflight[NREQ*4]   per-requester outstanding count, [i*4+:4]
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_share_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*53-1:0] req_in_1;
  logic [NREQ*27-1:0] req_in_2;
  logic [NREQ-1:0]    gnt;
  logic               mul_en;
  logic [52:0]        mul_in_1;
  logic [26:0]        mul_in_2;
  logic [79:0]        mul_out;
  logic [NREQ-1:0]    rvld;
  logic [79:0]        rslt;
  logic [NREQ*4-1:0]  inflight;

  modport slave (
    input  req, req_in_1, req_in_2, mul_out,
    output gnt, mul_en, mul_in_1, mul_in_2, rvld, rslt, inflight
  );

  modport master (
    output req, req_in_1, req_in_2, mul_out,
    input  gnt, mul_en, mul_in_1, mul_in_2, rvld, rslt, inflight
  );
endinterface
`default_nettype wire

// File: rtl/mul_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_arb
//  Description : Shares one fully pipelined 53x27 multiplier (fixed latency
//                LAT) between NREQ requesters. Grants at most one request per
//                cycle, round-robin (RR=1) or lowest-index-first (RR=0), with
//                a cap of MAXOUT outstanding operations per requester. A tag
//                pipeline remembers who issued each operation so the product
//                can be returned with a one-hot per-requester valid.
//  Ports       : clk    - clock, all state on rising edge
//                reset  - asynchronous, active-low reset
//                bus    - mul_share_arb_if.slave (requests, multiplier, results)
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_share_arb #(
  parameter int NREQ   = 2,
  parameter int LAT    = 3,
  parameter int MAXOUT = 2,
  parameter int RR     = 1
) (
  input  logic           clk,
  input  logic           reset,
  mul_share_arb_if.slave bus
);

  localparam int              c_IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]      c_MAX  = 4'(MAXOUT);
  localparam logic [c_IW-1:0] c_LAST = c_IW'(NREQ - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_IW-1:0] r_ptr;
  logic [3:0]      r_cnt   [NREQ];
  logic [LAT-1:0]  r_tag_v;
  logic [c_IW-1:0] r_tag_i [LAT];
  logic [NREQ-1:0] r_rvld;
  logic [79:0]     r_rslt;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic [NREQ-1:0] w_elig;
  logic            w_hit;
  logic [c_IW-1:0] w_widx;
  logic            w_en;
  logic [NREQ-1:0] w_gnt;
  logic [52:0]     w_a;
  logic [26:0]     w_b;
  logic [NREQ-1:0] w_done;

  // A completion in the current cycle is not visible here: the counter only
  // drops on the following edge, so the freed slot is usable next cycle.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
      assign w_elig[gi] = bus.req[gi] & (r_cnt[gi] < c_MAX);
    end
  endgenerate

  // Search NREQ candidates starting at the pointer (RR) or at index 0 (fixed
  // priority); the first eligible candidate wins.
  always_comb begin
    logic [c_IW-1:0] k;
    w_hit  = 1'b0;
    w_widx = '0;
    k      = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (RR != 0) begin
        k = c_IW'((int'(r_ptr) + off) % NREQ);
      end else begin
        k = c_IW'(off);
      end
      if (!w_hit && w_elig[k]) begin
        w_hit  = 1'b1;
        w_widx = k;
      end
    end
  end

  // Grant is suppressed for as long as reset is held.
  assign w_en = w_hit & reset;

  always_comb begin
    w_gnt = '0;
    if (w_en) begin
      w_gnt[w_widx] = 1'b1;
    end
  end

  // AND-OR operand mux; gnt is one-hot, and all-zero gives zero operands.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_a = w_a | ({53{w_gnt[i]}} & bus.req_in_1[i*53 +: 53]);
      w_b = w_b | ({27{w_gnt[i]}} & bus.req_in_2[i*27 +: 27]);
    end
  end

  // Tag at the last stage corresponds to the product currently on mul_out.
  always_comb begin
    w_done = '0;
    if (r_tag_v[LAT-1]) begin
      w_done[r_tag_i[LAT-1]] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin pointer: moves just past the winner, holds when idle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (w_en) begin
      r_ptr <= (w_widx == c_LAST) ? '0 : w_widx + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipeline: {valid, requester index} travels alongside the multiplier.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_v <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_tag_i[s] <= '0;
      end
    end else begin
      r_tag_v[0] <= w_en;
      r_tag_i[0] <= w_widx;
      for (int s = 1; s < LAT; s++) begin
        r_tag_v[s] <= r_tag_v[s-1];
        r_tag_i[s] <= r_tag_i[s-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result register: product is captured only when a tagged op completes,
  // otherwise the last product is held.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvld <= '0;
      r_rslt <= '0;
    end else begin
      r_rvld <= w_done;
      if (r_tag_v[LAT-1]) begin
        r_rslt <= bus.mul_out;
      end
    end
  end

  // --------------------------------------------------------------------------
  // In-flight counters: up on grant, down on returned result, unchanged when
  // both happen in the same cycle. The decrement is guarded so a stray rvld
  // can never wrap the counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({w_gnt[i], r_rvld[i]})
          2'b10: r_cnt[i] <= r_cnt[i] + 4'd1;
          2'b01: begin
            if (r_cnt[i] != 4'd0) begin
              r_cnt[i] <= r_cnt[i] - 4'd1;
            end
          end
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.gnt      = w_gnt;
  assign bus.mul_en   = w_en;
  assign bus.mul_in_1 = w_a;
  assign bus.mul_in_2 = w_b;
  assign bus.rvld     = r_rvld;
  assign bus.rslt     = r_rslt;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_inflight
      assign bus.inflight[gi*4 +: 4] = r_cnt[gi];
    end
  endgenerate

endmodule
`default_nettype wire
